// File: rtl/spi_rx_fifo.sv
// Receive-side word buffer for the SPI block: captures one frame per rising edge of LOAD
// and presents the queued words first-word-fall-through with a sticky overflow flag.
module spi_rx_fifo #(
   parameter int WIDTH = 15,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             RESET,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] RX_DAT,
   input  logic             rd,
   output logic [WIDTH-1:0] DO,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      count,
   output logic             ovf,
   input  logic             clr_ovf
);

   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_load_q;
   logic             r_ovf;

   logic             w_empty;
   logic             w_full;
   logic             w_wr_stb;
   logic             w_wr_en;
   logic             w_rd_en;
   logic             w_ovf_set;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == DEPTH_CNT);
   assign w_wr_stb  = LOAD & ~r_load_q;
   // When full, a coincident pop frees the head slot, which is exactly where wr_ptr points.
   assign w_wr_en   = w_wr_stb & (~w_full | rd);
   assign w_rd_en   = rd & ~w_empty;
   assign w_ovf_set = w_wr_stb & w_full & ~rd;

   // LOAD_q resets high so a LOAD already asserted at reset release is not a new frame.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         r_load_q <= 1'b1;
      end else begin
         r_load_q <= LOAD;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= RX_DAT;
      end
   end

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         r_count <= '0;
      end else begin
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // A new overflow in the same cycle as clr_ovf keeps the flag set.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         r_ovf <= 1'b0;
      end else if (w_ovf_set) begin
         r_ovf <= 1'b1;
      end else if (clr_ovf) begin
         r_ovf <= 1'b0;
      end
   end

   assign DO    = w_empty ? '0 : r_mem[r_rd_ptr];
   assign empty = w_empty;
   assign full  = w_full;
   assign count = r_count;
   assign ovf   = r_ovf;

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Directed bench for spi_rx_fifo: a queue model holds the expected words, checked at each pop.
module tb_spi_rx_fifo;

   localparam int WIDTH = 15;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic             clk = 1'b0;
   logic             RESET;
   logic             LOAD;
   logic [WIDTH-1:0] RX_DAT;
   logic             rd;
   logic [WIDTH-1:0] DO;
   logic             empty;
   logic             full;
   logic [AW:0]      count;
   logic             ovf;
   logic             clr_ovf;

   int vectors     = 0;
   int miscompares = 0;
   logic [WIDTH-1:0] sb[$];
   logic             exp_ovf = 1'b0;

   spi_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .RESET(RESET), .LOAD(LOAD), .RX_DAT(RX_DAT), .rd(rd),
      .DO(DO), .empty(empty), .full(full), .count(count), .ovf(ovf), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag);
      chk({tag, ".count"}, 32'(count), 32'(sb.size()));
      chk({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
      chk({tag, ".full"},  32'(full),  32'(sb.size() == DEPTH));
      chk({tag, ".ovf"},   32'(ovf),   32'(exp_ovf));
   endtask

   // One frame: LOAD high for one cycle, then low so the next frame sees a fresh edge.
   task automatic send_frame(input logic [WIDTH-1:0] d, input logic r, input logic clr);
      RX_DAT  = d;
      LOAD    = 1'b1;
      rd      = r;
      clr_ovf = clr;
      if (r && sb.size() > 0) begin
         chk("sim_rd.DO", 32'(DO), 32'(sb[0]));
         void'(sb.pop_front());
         sb.push_back(d);
      end else if (sb.size() < DEPTH) begin
         sb.push_back(d);
      end else begin
         exp_ovf = 1'b1;
      end
      if (clr && !(sb.size() == DEPTH && !r && exp_ovf)) exp_ovf = 1'b0;
      tick();
      LOAD    = 1'b0;
      rd      = 1'b0;
      clr_ovf = 1'b0;
      tick();
   endtask

   task automatic pop(input string tag);
      chk({tag, ".empty_before"}, 32'(empty), 32'(0));
      chk({tag, ".DO"}, 32'(DO), 32'(sb[0]));
      rd = 1'b1;
      tick();
      rd = 1'b0;
      void'(sb.pop_front());
      chk({tag, ".count_after"}, 32'(count), 32'(sb.size()));
   endtask

   initial begin
      RESET = 1'b0; LOAD = 1'b0; RX_DAT = '0; rd = 1'b0; clr_ovf = 1'b0;

      // async reset between edges
      #3 RESET = 1'b1;
      #1;
      chk_state("reset");
      chk("reset.DO", 32'(DO), 32'(0));
      LOAD = 1'b1;
      tick(); tick();
      #3 RESET = 1'b0;
      tick(); tick();
      chk_state("release_load_high");
      LOAD = 1'b0;
      tick();

      // single long frame
      RX_DAT = 15'h56AA;
      LOAD   = 1'b1;
      sb.push_back(15'h56AA);
      tick();
      chk_state("single.capture");
      chk("single.DO", 32'(DO), 32'(15'h56AA));
      for (int i = 0; i < 15; i++) tick();
      chk_state("single.held");
      LOAD = 1'b0;
      tick();
      pop("single.pop");
      chk_state("single.after");

      // ordering and pointer wrap
      for (int i = 1; i <= 12; i++) begin
         send_frame(15'(i), 1'b0, 1'b0);
         chk("order.count_le5", 32'(count <= 5), 32'(1));
         if (sb.size() >= 4) pop("order.pop");
      end
      while (sb.size() > 0) pop("order.drain");
      chk_state("order.done");

      // full and overflow
      for (int i = 0; i < 8; i++) send_frame(15'h7C33 + 15'(i), 1'b0, 1'b0);
      chk_state("full.fill");
      send_frame(15'h1111, 1'b0, 1'b0);
      chk_state("full.overflow");
      send_frame(15'h1234, 1'b0, 1'b1);
      chk_state("full.set_wins");
      for (int i = 0; i < 8; i++) pop("full.drain");
      chk_state("full.drained");
      clr_ovf = 1'b1;
      exp_ovf = 1'b0;
      tick();
      clr_ovf = 1'b0;
      chk_state("full.clr_ovf");

      // simultaneous write + read
      for (int i = 0; i < 8; i++) send_frame(15'h0100 + 15'(i), 1'b0, 1'b0);
      chk_state("sim.fill");
      send_frame(15'h2222, 1'b1, 1'b0);
      chk_state("sim.full_wr_rd");
      for (int i = 0; i < 8; i++) pop("sim.drain");
      chk_state("sim.drained");
      send_frame(15'h3333, 1'b1, 1'b0);
      chk_state("sim.empty_wr_rd");
      chk("sim.empty_DO", 32'(DO), 32'(15'h3333));
      pop("sim.pop3333");

      // mid-operation reset
      for (int i = 0; i < 4; i++) send_frame(15'h0200 + 15'(i), 1'b0, 1'b0);
      chk_state("midrst.queued");
      #2 RESET = 1'b1;
      #1;
      sb.delete();
      chk_state("midrst.async");
      chk("midrst.DO", 32'(DO), 32'(0));
      #1 RESET = 1'b0;
      tick();
      send_frame(15'h0ABC, 1'b0, 1'b0);
      chk_state("midrst.refill");
      pop("midrst.first");
      chk_state("midrst.done");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
